inta_sequencer: RTL

//  CPU-side initiator of the 8259A interrupt-acknowledge protocol: the other end of the PIC control logic.

---
 rtl/inta_sequencer_pkg.sv | 14 +
 rtl/inta_pulse_timer.sv | 26 ++
 rtl/inta_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/inta_sequencer_pkg.sv
// Shared definitions for the 8259A interrupt-acknowledge initiator: FSM states and INTA levels.
package inta_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_GAP  = 2'd2,
        ST_ACK2 = 2'd3
    } inta_state_e;

    localparam logic INTA_ACTIVE = 1'b0;
    localparam logic INTA_IDLE   = 1'b1;

endpackage

// File: rtl/inta_pulse_timer.sv
// Shared pulse/gap counter: counts up while enabled, terminal count when cnt equals the given limit.
module inta_pulse_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == limit);

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side 8259A INTA sequencer: two INTA pulses, vector capture on the second, valid/ready to the core.
// Optional abort on a dropped request at the end of pulse 1: define INTA_SPURIOUS_CHK_EN.
module inta_sequencer
    import inta_sequencer_pkg::*;
#(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INT,
    input  logic       int_en,
    input  logic [7:0] DATA_IN,
    output logic       INTA,
    output logic [7:0] vec_out,
    output logic       vec_valid,
    input  logic       vec_ready,
    output logic       busy,
    output logic       spurious
);

    localparam logic [CNT_W-1:0] PULSE_LIM = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(GAP_CYCLES - 1);

    inta_state_e      state;
    logic             tc;
    logic             tmr_clr;
    logic [CNT_W-1:0] tmr_limit;

    // Every exit from a counting state happens on terminal count, so clearing on tc
    // (and holding clear in IDLE) restarts the counter on each transition.
    assign tmr_clr   = (state == ST_IDLE) || tc;
    assign tmr_limit = (state == ST_GAP) ? GAP_LIM : PULSE_LIM;

    inta_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (1'b1),
        .limit (tmr_limit),
        .tc    (tc)
    );

`ifdef INTA_SPURIOUS_CHK_EN
    logic spurious_q;
    assign spurious = spurious_q;
`else
    assign spurious = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            INTA      <= INTA_IDLE;
            vec_out   <= 8'h00;
            vec_valid <= 1'b0;
`ifdef INTA_SPURIOUS_CHK_EN
            spurious_q <= 1'b0;
`endif
        end else begin
`ifdef INTA_SPURIOUS_CHK_EN
            spurious_q <= 1'b0;
`endif
            if (vec_valid && vec_ready)
                vec_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // Single-entry buffer: a pending vector blocks the next acknowledge.
                    if (INT && int_en && !vec_valid) begin
                        state <= ST_ACK1;
                        INTA  <= INTA_ACTIVE;
                    end
                end
                ST_ACK1: begin
                    if (tc) begin
                        INTA <= INTA_IDLE;
`ifdef INTA_SPURIOUS_CHK_EN
                        if (!INT) begin
                            state      <= ST_IDLE;
                            spurious_q <= 1'b1;
                        end else
`endif
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tc) begin
                        state <= ST_ACK2;
                        INTA  <= INTA_ACTIVE;
                    end
                end
                ST_ACK2: begin
                    if (tc) begin
                        state     <= ST_IDLE;
                        INTA      <= INTA_IDLE;
                        vec_out   <= DATA_IN;
                        vec_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    INTA  <= INTA_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
